jk_cmd_sequencer: RTL and testbench
===================================

# jk_cmd_sequencer

Upstream command stage for the JK flip-flop (`flipflopjk`). Accepts queued flip-flop operations (hold, reset, set, toggle) with a repeat count over a valid/ready handshake, buffers them in a small FIFO, and drives the flip-flop's J/K inputs one operation at a time for the requested number of cycles. Its `oJ`/`oK` connect directly to `iJ`/`iK` of `flipflopjk`, which shares the same `iClk`.

## Interface
- `DEPTH`, 4 — FIFO entries; power of two, ≥2.
- `CNT_W`, 4 — width of the repeat count.

- `iClk` in 1 — single clock; all state updates on its rising edge.
- `iRst` in 1 — asynchronous, active-high reset.
- `iValid` in 1 — a command is presented on `iOp`/`iRep`.
- `oReady` in/out: out 1 — the FIFO can accept a command.
- `iOp` in 2 — operation: 00 hold, 01 reset, 10 set, 11 toggle.
- `iRep` in CNT_W — apply the operation for `iRep`+1 consecutive cycles.
- `iAbort` in 1 — synchronous flush of the FIFO and the active command.
- `oJ` out 1 — J drive to the flip-flop.
- `oK` out 1 — K drive to the flip-flop.
- `oBusy` out 1 — a command is being applied.
- `oLast` out 1 — the current cycle is the final cycle of the active command.
- `oEmpty` out 1 — FIFO holds no commands.
- `oFull` out 1 — FIFO holds `DEPTH` commands.

## Operation
- **Op to J/K mapping:** hold → J=0, K=0; reset → J=0, K=1; set → J=1, K=0; toggle → J=1, K=1.
- **FIFO:** `DEPTH` entries, each `2+CNT_W` bits. Read and write pointers are `log2(DEPTH)` bits wide and wrap modulo `DEPTH`. An occupancy counter is `log2(DEPTH)+1` bits.
- **Push:** occurs on an edge where `iValid && oReady && !iAbort`.
- **Ready:** `oReady = !oFull`, derived from registered occupancy only. A pop in the same cycle does not enable a push into a full FIFO.
- **State machine:**
  - IDLE (`oJ`=`oK`=0, `oBusy`=0) → APPLY when the FIFO is non-empty at an edge. On that edge, pop the head and load the op register and the down-counter (`rem` = `iRep`).
  - APPLY: `oJ`/`oK` follow the op register. At each edge, if `rem` ≠ 0, decrement `rem`.
  - APPLY with `rem` = 0 (this is `oLast`=1): at the next edge, if the FIFO is non-empty, pop and load the next command with no gap cycle and stay in APPLY; otherwise go to IDLE.
- **Push into an empty FIFO:** the entry is not visible for a pop until the following edge. There is no bypass path.
- **Abort:** `iAbort` at an edge empties the FIFO (pointers and count to 0), forces IDLE, and ignores any simultaneous push. Abort takes precedence over push and pop.
- **Outputs:** `oJ` and `oK` are registered outputs. `oLast` = APPLY && `rem`==0. `oEmpty` and `oFull` are computed from the occupancy count.

## Timing
- **Reset values (immediate, asynchronous):** `oJ`=0, `oK`=0, `oBusy`=0, `oLast`=0, `oEmpty`=1, `oFull`=0, `oReady`=1. State = IDLE, pointers and count = 0.
- **Deassertion of `iRst`** is synchronised externally. The first push is accepted at the first rising edge after deassertion.
- **Latency:** a command pushed at edge t into an idle, empty sequencer has `oJ`/`oK` valid after edge t+1. Those values stay applied for `iRep`+1 cycles.
- **Back-to-back commands:** `oJ`/`oK` change directly from one op to the next at the edge following `oLast`, with no hold cycle inserted.
- **Simultaneous push and pop** when non-empty and non-full: the occupancy count is unchanged and both pointers advance.
- **`iRep` = all ones:** the command lasts 2^CNT_W cycles and the counter does not wrap.
- **Reset mid-APPLY:** the outputs drop to 0 immediately, without waiting for an edge, and all queued commands are lost.

## Test plan
- **Reset:** assert `iRst` mid-APPLY while set is active → `oJ`=`oK`=0 without waiting for an edge; `oEmpty`=1; `oReady`=1.
- **Single command:** push set, `iRep`=2, at edge t → `oJ`=1, `oK`=0 after edges t+1..t+3. `oLast` is high only in the third cycle. After edge t+4, IDLE with `oJ`=`oK`=0. The downstream `flipflopjk` gives `oQ`=1.
- **Back-to-back:** push set/rep0, reset/rep1, toggle/rep0 on consecutive cycles → J/K sequence 10, 01, 01, 11, then 00, with no gaps. `oQ` follows 1, 0, 0, 1.
- **Full and wrap-around:** with `DEPTH`=4, push 4 commands with rep15 while the first is active → `oFull`=1 and `oReady`=0. A 5th `iValid` is ignored. Push/pop more than 8 commands so the pointers wrap → every command is executed in order.
- **Abort:** while APPLY is active with 3 queued entries, pulse `iAbort` together with `iValid` → after the edge: IDLE, `oEmpty`=1, `oJ`=`oK`=0, and the simultaneous command is not stored.
- **Push while popping at full:** with `oFull`=1 and `oLast`=1, assert `iValid` → not accepted on that edge. The count drops to 3, `oReady`=1 on the next cycle, and the push is accepted at the following edge.

Source files
------------

// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: queues hold/reset/set/toggle commands with a repeat
// count and drives a JK flip-flop's J/K inputs one command at a time.
// Ports: iClk, iRst (async, high), iValid/oReady/iOp/iRep command input,
// iAbort flush, oJ/oK drive, oBusy/oLast status, oEmpty/oFull FIFO state.
module jk_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iValid,
    output logic             oReady,
    input  logic [1:0]       iOp,
    input  logic [CNT_W-1:0] iRep,
    input  logic             iAbort,
    output logic             oJ,
    output logic             oK,
    output logic             oBusy,
    output logic             oLast,
    output logic             oEmpty,
    output logic             oFull
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 + CNT_W;

    typedef enum logic {
        IDLE,
        APPLY
    } state_t;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [CNT_W-1:0] rem;
    state_t        state;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    assign oEmpty = (count == '0);
    assign oFull  = (count == (AW+1)'(DEPTH));
    // Ready comes from registered occupancy only: a pop on the same
    // edge never frees room for a push into a full FIFO.
    assign oReady = !oFull;
    assign oBusy  = (state == APPLY);
    assign oLast  = (state == APPLY) && (rem == '0);

    assign push = iValid && oReady && !iAbort;
    // Pop when idle or on the final cycle of the active command.
    assign pop  = !oEmpty && ((state == IDLE) || oLast);
    assign head = mem[rd_ptr];

    always_ff @(posedge iClk) begin
        if (push) begin
            mem[wr_ptr] <= {iOp, iRep};
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rem    <= '0;
            oJ     <= 1'b0;
            oK     <= 1'b0;
        end else if (iAbort) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rem    <= '0;
            oJ     <= 1'b0;
            oK     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case (1'b1)
                (push && !pop): count <= count + 1'b1;
                (pop && !push): count <= count - 1'b1;
                default:        count <= count;
            endcase

            unique case (state)
                IDLE: begin
                    if (pop) begin
                        state <= APPLY;
                        rem   <= head[CNT_W-1:0];
                        oJ    <= head[EW-1];
                        oK    <= head[EW-2];
                    end
                end
                APPLY: begin
                    if (rem != '0) begin
                        rem <= rem - 1'b1;
                    end else if (pop) begin
                        // Chain straight into the next command, no gap.
                        rem <= head[CNT_W-1:0];
                        oJ  <= head[EW-1];
                        oK  <= head[EW-2];
                    end else begin
                        state <= IDLE;
                        oJ    <= 1'b0;
                        oK    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Testbench for jk_cmd_sequencer: queue-level reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_jk_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             iClk;
    logic             iRst;
    logic             iValid;
    logic             oReady;
    logic [1:0]       iOp;
    logic [CNT_W-1:0] iRep;
    logic             iAbort;
    logic             oJ;
    logic             oK;
    logic             oBusy;
    logic             oLast;
    logic             oEmpty;
    logic             oFull;

    int checks = 0;
    int errors = 0;

    jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .iClk(iClk),
        .iRst(iRst),
        .iValid(iValid),
        .oReady(oReady),
        .iOp(iOp),
        .iRep(iRep),
        .iAbort(iAbort),
        .oJ(oJ),
        .oK(oK),
        .oBusy(oBusy),
        .oLast(oLast),
        .oEmpty(oEmpty),
        .oFull(oFull)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Reference model: a command queue plus the active command and the
    // number of cycles it still has to be applied (including this one).
    typedef struct {
        logic [1:0] op;
        int         rep;
    } cmd_t;

    cmd_t       mq[$];
    bit         m_act;
    logic [1:0] m_op;
    int         m_left;

    task automatic model_reset();
        mq.delete();
        m_act  = 1'b0;
        m_op   = 2'b00;
        m_left = 0;
    endtask

    task automatic model_edge();
        bit   acc;
        cmd_t c;
        cmd_t h;
        if (iRst || iAbort) begin
            model_reset();
            return;
        end
        acc   = iValid && (mq.size() < DEPTH);
        c.op  = iOp;
        c.rep = int'(iRep);
        if ((!m_act || m_left == 1) && mq.size() > 0) begin
            h      = mq.pop_front();
            m_act  = 1'b1;
            m_op   = h.op;
            m_left = h.rep + 1;
        end else if (m_act) begin
            if (m_left == 1) m_act = 1'b0;
            else m_left--;
        end
        if (acc) mq.push_back(c);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge iClk);
            model_edge();
        end
    end

    // Downstream JK flip-flop, as the sequencer's consumer would see it.
    logic ff_q = 1'b0;
    initial begin
        forever begin
            @(posedge iClk or posedge iRst);
            if (iRst) ff_q = 1'b0;
            else begin
                case ({oJ, oK})
                    2'b01:   ff_q = 1'b0;
                    2'b10:   ff_q = 1'b1;
                    2'b11:   ff_q = ~ff_q;
                    default: ff_q = ff_q;
                endcase
            end
        end
    end

    initial begin
        forever begin
            @(negedge iClk);
            if (!iRst) begin
                chk("m_j", oJ, m_act ? m_op[1] : 1'b0);
                chk("m_k", oK, m_act ? m_op[0] : 1'b0);
                chk("m_busy", oBusy, m_act);
                chk("m_last", oLast, m_act && m_left == 1);
                chk("m_empty", oEmpty, mq.size() == 0);
                chk("m_full", oFull, mq.size() == DEPTH);
                chk("m_ready", oReady, mq.size() < DEPTH);
            end
        end
    end

    task automatic tick();
        @(posedge iClk);
        #2;
    endtask

    task automatic push(input logic [1:0] op, input int rep);
        int n;
        n      = 0;
        iValid = 1'b1;
        iOp    = op;
        iRep   = CNT_W'(rep);
        while (!oReady && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL push_timeout: got busy expected ready");
        end
        tick();
        iValid = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while (!(oEmpty && !oBusy) && n < lim) begin
            tick();
            n++;
        end
        checks++;
        if (n >= lim) begin
            errors++;
            $display("FAIL idle_timeout: got busy expected idle");
        end
    endtask

    initial begin
        iRst   = 1'b1;
        iValid = 1'b0;
        iOp    = 2'b00;
        iRep   = '0;
        iAbort = 1'b0;
        #1;
        chk("rst_ready", oReady, 1);
        chk("rst_empty", oEmpty, 1);
        chk("rst_full", oFull, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_j", oJ, 0);
        chk("rst_last", oLast, 0);
        tick();
        tick();
        iRst = 1'b0;

        // Single set command, rep 2
        iValid = 1'b1; iOp = 2'b10; iRep = 4'd2;
        tick();
        iValid = 1'b0;
        chk("s_busy0", oBusy, 0);
        tick();
        chk("s_j1", oJ, 1);
        chk("s_k1", oK, 0);
        chk("s_last1", oLast, 0);
        tick();
        chk("s_last2", oLast, 0);
        chk("s_j2", oJ, 1);
        tick();
        chk("s_last3", oLast, 1);
        chk("s_j3", oJ, 1);
        tick();
        chk("s_busy4", oBusy, 0);
        chk("s_j4", oJ, 0);
        chk("s_q", ff_q, 1);

        // Back-to-back: set/0, reset/1, toggle/0
        iValid = 1'b1; iOp = 2'b10; iRep = 4'd0;
        tick();
        iOp = 2'b01; iRep = 4'd1;
        tick();
        chk("b_jk1", {oJ, oK}, 2'b10);
        iOp = 2'b11; iRep = 4'd0;
        tick();
        iValid = 1'b0;
        chk("b_jk2", {oJ, oK}, 2'b01);
        chk("b_q2", ff_q, 1);
        tick();
        chk("b_jk3", {oJ, oK}, 2'b01);
        chk("b_q3", ff_q, 0);
        tick();
        chk("b_jk4", {oJ, oK}, 2'b11);
        chk("b_q4", ff_q, 0);
        tick();
        chk("b_jk5", {oJ, oK}, 2'b00);
        chk("b_q5", ff_q, 1);

        // Fill with rep15 commands while the first is active
        iValid = 1'b1; iRep = 4'd15;
        for (int i = 0; i < 5; i++) begin
            iOp = 2'(i);
            tick();
        end
        chk("f_full", oFull, 1);
        chk("f_ready", oReady, 0);
        iOp = 2'b01;
        tick();
        iValid = 1'b0;
        chk("f_full2", oFull, 1);
        wait_idle(200);

        // Enough commands to wrap both pointers
        for (int i = 0; i < 10; i++) begin
            push(2'(i % 4), i % 3);
        end
        wait_idle(200);

        // Push attempt while full and on the last cycle
        iValid = 1'b1; iOp = 2'b10; iRep = 4'd3;
        tick();
        iOp = 2'b01; iRep = 4'd0;
        for (int i = 0; i < 4; i++) tick();
        chk("p_full", oFull, 1);
        chk("p_last", oLast, 1);
        iOp = 2'b11; iRep = 4'd1;
        tick();
        chk("p_ready", oReady, 1);
        chk("p_full2", oFull, 0);
        tick();
        iValid = 1'b0;
        chk("p_empty", oEmpty, 0);
        wait_idle(100);

        // Abort with three queued entries and a simultaneous push
        iValid = 1'b1; iOp = 2'b10; iRep = 4'd15;
        for (int i = 0; i < 4; i++) tick();
        chk("a_busy", oBusy, 1);
        chk("a_empty", oEmpty, 0);
        iAbort = 1'b1; iOp = 2'b11;
        tick();
        iAbort = 1'b0; iValid = 1'b0;
        chk("a_busy2", oBusy, 0);
        chk("a_empty2", oEmpty, 1);
        chk("a_jk", {oJ, oK}, 2'b00);
        chk("a_ready", oReady, 1);
        tick(); tick(); tick();
        chk("a_empty3", oEmpty, 1);
        chk("a_busy3", oBusy, 0);

        // Asynchronous reset while set is being applied
        iValid = 1'b1; iOp = 2'b10; iRep = 4'd15;
        tick();
        iOp = 2'b01;
        tick();
        iValid = 1'b0;
        tick();
        chk("r_j_pre", oJ, 1);
        iRst = 1'b1;
        #1;
        chk("r_j", oJ, 0);
        chk("r_k", oK, 0);
        chk("r_empty", oEmpty, 1);
        chk("r_ready", oReady, 1);
        chk("r_busy", oBusy, 0);
        model_reset();
        tick();
        iRst = 1'b0;
        tick(); tick();
        chk("r_idle", oBusy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
